// File: rtl/inert_pkg.sv
// Shared types and SPI command tables for the inertial sensor sequencer.
package inert_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_REQ,
    INIT_ACK,
    IDLE,
    RD_REQ,
    RD_ACK
  } state_t;

  localparam int NUM_INIT = 4;
  localparam int NUM_RD   = 4;
  localparam logic [1:0] LAST_INIT = 2'(NUM_INIT - 1);
  localparam logic [1:0] LAST_RD   = 2'(NUM_RD - 1);

  // Configuration writes: INT enable, accel 208Hz/2g, gyro 208Hz/250dps, rounding
  localparam logic [15:0] INIT_CMD_0 = 16'h0D02;
  localparam logic [15:0] INIT_CMD_1 = 16'h1053;
  localparam logic [15:0] INIT_CMD_2 = 16'h1150;
  localparam logic [15:0] INIT_CMD_3 = 16'h1460;

  // Byte reads: pitchL, pitchH, AZL, AZH
  localparam logic [15:0] RD_CMD_0 = 16'hA200;
  localparam logic [15:0] RD_CMD_1 = 16'hA300;
  localparam logic [15:0] RD_CMD_2 = 16'hAC00;
  localparam logic [15:0] RD_CMD_3 = 16'hAD00;

  function automatic logic [15:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0: return INIT_CMD_0;
      2'd1: return INIT_CMD_1;
      2'd2: return INIT_CMD_2;
      default: return INIT_CMD_3;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    case (i)
      2'd0: return RD_CMD_0;
      2'd1: return RD_CMD_1;
      2'd2: return RD_CMD_2;
      default: return RD_CMD_3;
    endcase
  endfunction

endpackage

// File: rtl/inert_int_sync.sv
// Two-flop synchronizer bringing the sensor interrupt into the clk domain.
module inert_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inert_seq_ctrl.sv
// Sensor SPI sequencer: power-up wait, configuration writes, then one
// four-byte read per data-ready interrupt producing ptch_rt/AZ with a vld pulse.
module inert_seq_ctrl
  import inert_pkg::*;
#(
  parameter int INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output state_t      dbg_state
);

  // SPI handshake: wrt is a one-cycle request with cmd already valid; cmd holds
  // until the master answers with a one-cycle done, which is only honoured in
  // the *_ACK states so a stray done can never advance the sequence.

  localparam logic [INIT_WAIT_BITS-1:0] CNT_ONE = {{(INIT_WAIT_BITS-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic [INIT_WAIT_BITS-1:0] wait_cnt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] cmd_nxt;
  logic [7:0]  pitch_l, pitch_h, az_l;
  logic        int_s;
  logic        cap, fin;
  logic        cnt_full;
  logic        unused_rd_hi;

  assign cnt_full     = &wait_cnt;
  assign unused_rd_hi = ^rd_data[15:8];
  assign dbg_state    = state;

  inert_int_sync u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cmd_nxt   = cmd;
    wrt       = 1'b0;
    cap       = 1'b0;
    fin       = 1'b0;
    case (state)
      INIT_WAIT: begin
        if (cnt_full) begin
          state_nxt = INIT_REQ;
          idx_nxt   = 2'd0;
          cmd_nxt   = init_cmd(2'd0);
        end
      end
      INIT_REQ: begin
        wrt       = 1'b1;
        state_nxt = INIT_ACK;
      end
      INIT_ACK: begin
        if (done) begin
          if (idx == LAST_INIT) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            cmd_nxt   = init_cmd(idx + 2'd1);
            state_nxt = INIT_REQ;
          end
        end
      end
      IDLE: begin
        if (int_s) begin
          idx_nxt   = 2'd0;
          cmd_nxt   = rd_cmd(2'd0);
          state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        wrt       = 1'b1;
        state_nxt = RD_ACK;
      end
      RD_ACK: begin
        if (done) begin
          if (idx == LAST_RD) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else begin
            cap       = 1'b1;
            idx_nxt   = idx + 2'd1;
            cmd_nxt   = rd_cmd(idx + 2'd1);
            state_nxt = RD_REQ;
          end
        end
      end
      default: state_nxt = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_WAIT;
      idx      <= 2'd0;
      cmd      <= 16'h0000;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cmd   <= cmd_nxt;
      // Counter parks at all ones and is never reused after init
      if (state == INIT_WAIT && !cnt_full)
        wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pitch_l <= 8'h00;
      pitch_h <= 8'h00;
      az_l    <= 8'h00;
      vld     <= 1'b0;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
    end else begin
      vld <= fin;
      if (cap) begin
        case (idx)
          2'd0:    pitch_l <= rd_data[7:0];
          2'd1:    pitch_h <= rd_data[7:0];
          default: az_l    <= rd_data[7:0];
        endcase
      end
      // AZH goes straight from the bus so both words update on the same edge
      if (fin) begin
        ptch_rt <= {pitch_h, pitch_l};
        AZ      <= {rd_data[7:0], az_l};
      end
    end
  end

endmodule

// File: tb/tb_inert_seq_ctrl.sv
// Bench for inert_seq_ctrl: SPI slave model, command/sample scoreboard, table and random samples.
module tb_inert_seq_ctrl;
  import inert_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  state_t      dbg_state;

  inert_seq_ctrl #(.INIT_WAIT_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .cmd       (cmd),
    .vld       (vld),
    .ptch_rt   (ptch_rt),
    .AZ        (AZ),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_p_q[$];
  logic [15:0] exp_a_q[$];
  logic [7:0]  cur_b [4];
  logic [7:0]  sent  [4];
  int wrt_cnt = 0, vld_cnt = 0;
  int spi_lat = 10;
  bit spi_rand = 0, spur_idle = 0, spur_on_wrt = 0, int_hold = 0;
  bit gap_chk = 0, fw_armed = 0;
  int gap_base = 0, last_vld_cyc = 0, first_wrt_cyc = 0, rel_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_reads();
    exp_q.push_back(16'hA200);
    exp_q.push_back(16'hA300);
    exp_q.push_back(16'hAC00);
    exp_q.push_back(16'hAD00);
  endtask

  task automatic push_inits();
    exp_q.push_back(16'h0D02);
    exp_q.push_back(16'h1053);
    exp_q.push_back(16'h1150);
    exp_q.push_back(16'h1460);
  endtask

  // ---------------- SPI slave model + output monitor (negedge) ----------------
  initial begin
    int pend;
    logic [15:0] pend_data;
    logic [15:0] e;
    logic [7:0]  b;
    int k;
    pend = 0;
    pend_data = 16'h0;
    done = 1'b0;
    rd_data = 16'h0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst_n) begin
        pend = 0;
        continue;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          done = 1'b1;
          rd_data = pend_data;
        end
      end else if (spur_idle) begin
        done = 1'b1;
        rd_data = 16'($urandom);
      end
      if (wrt) begin
        wrt_cnt++;
        if (fw_armed) begin
          fw_armed = 0;
          first_wrt_cyc = cyc;
        end
        chk("wrt_while_busy", {31'd0, pend != 0}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_wrt: cmd %h with no request expected", cmd);
          e = cmd;
        end else begin
          e = exp_q.pop_front();
          chk("cmd", {16'd0, cmd}, {16'd0, e});
        end
        if (gap_chk && e == 16'hA200 && vld_cnt > gap_base)
          chk("seq_gap_le2", {31'd0, (cyc - last_vld_cyc) <= 2}, 32'd1);
        case (e)
          16'hA200: k = 0;
          16'hA300: k = 1;
          16'hAC00: k = 2;
          16'hAD00: k = 3;
          default:  k = -1;
        endcase
        b = (k >= 0) ? cur_b[k] : 8'($urandom);
        if (k >= 0) sent[k] = b;
        if (k == 3) begin
          exp_p_q.push_back({sent[1], sent[0]});
          exp_a_q.push_back({sent[3], sent[2]});
          if (int_hold) push_reads();
        end
        pend_data = {8'($urandom), b};
        pend = spi_rand ? $urandom_range(1, 5) : spi_lat;
        if (spur_on_wrt) begin
          done = 1'b1;
          rd_data = 16'($urandom);
        end
      end
      if (vld) begin
        vld_cnt++;
        last_vld_cyc = cyc;
        if (exp_p_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_vld: ptch_rt %h AZ %h", ptch_rt, AZ);
        end else begin
          chk("vld_ptch_rt", {16'd0, ptch_rt}, {16'd0, exp_p_q.pop_front()});
          chk("vld_AZ", {16'd0, AZ}, {16'd0, exp_a_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_cnt_ge(input string nm, input bit is_vld, input int target, input int limit);
    int n = 0;
    while (((is_vld ? vld_cnt : wrt_cnt) < target) && n < limit) begin
      tick(1);
      n++;
    end
    chk(nm, {31'd0, (is_vld ? vld_cnt : wrt_cnt) >= target}, 32'd1);
  endtask

  task automatic wait_init(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || dbg_state != IDLE) && n < 400) begin
      tick(1);
      n++;
    end
    chk(nm, {31'd0, exp_q.size() == 0 && dbg_state == IDLE}, 32'd1);
    n_cmp++;
    if ((first_wrt_cyc - rel_cyc) < 16 || (first_wrt_cyc - rel_cyc) > 17) begin
      n_err++;
      $display("FAIL first_wrt_latency: got %0d cycles, required 16..17", first_wrt_cyc - rel_cyc);
    end
  endtask

  task automatic release_reset();
    push_inits();
    rst_n = 1'b1;
    rel_cyc = cyc;
    fw_armed = 1;
  endtask

  task automatic do_sample(input logic [7:0] b0, b1, b2, b3);
    int v0, w0;
    cur_b[0] = b0; cur_b[1] = b1; cur_b[2] = b2; cur_b[3] = b3;
    push_reads();
    v0 = vld_cnt;
    w0 = wrt_cnt;
    INT = 1'b1;
    wait_cnt_ge("int_start", 0, w0 + 1, 20);
    INT = 1'b0;
    wait_cnt_ge("sample_vld", 1, v0 + 1, 300);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wrt"}, {31'd0, wrt}, 32'd0);
    chk({tag, "_cmd"}, {16'd0, cmd}, 32'd0);
    chk({tag, "_vld"}, {31'd0, vld}, 32'd0);
    chk({tag, "_ptch_rt"}, {16'd0, ptch_rt}, 32'd0);
    chk({tag, "_AZ"}, {16'd0, AZ}, 32'd0);
    chk({tag, "_state"}, {29'd0, dbg_state}, {29'd0, INIT_WAIT});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [7:0]  pl, ph, al, ah;
    logic [15:0] ep, ea;
  } vec_t;

  vec_t tbl [4];

  // ---------------- main sequence ----------------
  initial begin
    int v0, w0;
    logic [7:0] r0, r1, r2, r3;
    tbl[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 16'h1234, 16'h5678};
    tbl[1] = '{8'hF0, 8'hFF, 8'h00, 8'h80, 16'hFFF0, 16'h8000};
    tbl[2] = '{8'hFF, 8'h7F, 8'h01, 8'h00, 16'h7FFF, 16'h0001};
    tbl[3] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 16'h0000, 16'hFFFF};
    INT = 1'b0;
    rst_n = 1'b0;
    tick(3);
    chk_reset_outputs("reset");

    // Power-up wait and configuration writes
    spi_lat = 10;
    release_reset();
    wait_init("init_complete");

    // No traffic without an interrupt
    v0 = vld_cnt; w0 = wrt_cnt;
    tick(30);
    chk("quiet_wrt", wrt_cnt, w0);
    chk("quiet_vld", vld_cnt, v0);

    // Table-driven samples
    for (int i = 0; i < 4; i++) begin
      spi_lat = (i == 0) ? 10 : 2 + i;
      do_sample(tbl[i].pl, tbl[i].ph, tbl[i].al, tbl[i].ah);
      chk("tbl_ptch_rt", {16'd0, ptch_rt}, {16'd0, tbl[i].ep});
      chk("tbl_AZ", {16'd0, AZ}, {16'd0, tbl[i].ea});
      tick(5);
      chk("tbl_ptch_hold", {16'd0, ptch_rt}, {16'd0, tbl[i].ep});
      chk("tbl_AZ_hold", {16'd0, AZ}, {16'd0, tbl[i].ea});
    end

    // Spurious done in IDLE
    v0 = vld_cnt; w0 = wrt_cnt;
    spur_idle = 1;
    tick(6);
    spur_idle = 0;
    tick(4);
    chk("spur_idle_wrt", wrt_cnt, w0);
    chk("spur_idle_vld", vld_cnt, v0);

    // done coincident with wrt, INT toggling while waiting in RD_ACK
    spi_lat = 10;
    spur_on_wrt = 1;
    cur_b[0] = 8'hA5; cur_b[1] = 8'h5A; cur_b[2] = 8'h3C; cur_b[3] = 8'hC3;
    push_reads();
    v0 = vld_cnt; w0 = wrt_cnt;
    INT = 1'b1;
    wait_cnt_ge("tog_start", 0, w0 + 1, 20);
    for (int i = 0; i < 8; i++) begin
      INT = ~INT;
      tick(1);
    end
    INT = 1'b0;
    wait_cnt_ge("tog_vld", 1, v0 + 1, 300);
    spur_on_wrt = 0;
    tick(30);
    chk("tog_one_vld", vld_cnt, v0 + 1);
    chk("tog_four_wrt", wrt_cnt, w0 + 4);
    chk("tog_ptch_rt", {16'd0, ptch_rt}, 32'h5AA5);
    chk("tog_AZ", {16'd0, AZ}, 32'hC33C);

    // Randomized samples against the assembled-word model
    spi_rand = 1;
    for (int i = 0; i < 16; i++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      do_sample(r0, r1, r2, r3);
      chk("rnd_ptch_rt", {16'd0, ptch_rt}, {16'd0, r1, r0});
      chk("rnd_AZ", {16'd0, AZ}, {16'd0, r3, r2});
      tick($urandom_range(0, 4));
    end
    spi_rand = 0;

    // Interrupt held high: back-to-back sequences
    spi_lat = 2;
    cur_b[0] = 8'h11; cur_b[1] = 8'h22; cur_b[2] = 8'h33; cur_b[3] = 8'h44;
    push_reads();
    gap_base = vld_cnt;
    v0 = vld_cnt; w0 = wrt_cnt;
    int_hold = 1;
    gap_chk = 1;
    INT = 1'b1;
    wait_cnt_ge("cont_three_vld", 1, v0 + 3, 400);
    INT = 1'b0;
    int_hold = 0;
    wait_cnt_ge("cont_fourth_vld", 1, v0 + 4, 200);
    tick(30);
    gap_chk = 0;
    chk("cont_vld_total", vld_cnt, v0 + 4);
    chk("cont_wrt_total", wrt_cnt, w0 + 16);
    chk("cont_q_drained", exp_q.size(), 0);
    chk("cont_ptch_rt", {16'd0, ptch_rt}, 32'h2211);
    chk("cont_AZ", {16'd0, AZ}, 32'h4433);

    // Reset while waiting for the third byte
    spi_lat = 3;
    cur_b[0] = 8'h01; cur_b[1] = 8'h02; cur_b[2] = 8'h03; cur_b[3] = 8'h04;
    push_reads();
    w0 = wrt_cnt;
    INT = 1'b1;
    wait_cnt_ge("rst_seq_start", 0, w0 + 1, 20);
    INT = 1'b0;
    wait_cnt_ge("rst_seq_third", 0, w0 + 3, 100);
    chk("rst_in_rd_ack", {29'd0, dbg_state}, {29'd0, RD_ACK});
    rst_n = 1'b0;
    exp_q.delete();
    exp_p_q.delete();
    exp_a_q.delete();
    #1;
    chk_reset_outputs("midrst");
    tick(3);
    chk_reset_outputs("midrst_hold");
    spi_lat = 10;
    release_reset();
    wait_init("reinit_complete");
    chk("reinit_ptch_rt", {16'd0, ptch_rt}, 32'd0);
    chk("reinit_AZ", {16'd0, AZ}, 32'd0);
    spi_lat = 2;
    do_sample(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    chk("post_rst_ptch_rt", {16'd0, ptch_rt}, 32'hBEEF);
    chk("post_rst_AZ", {16'd0, AZ}, 32'hDEAD);
    tick(10);
    chk("final_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inert_seq_ctrl.md
Name: inert_seq_ctrl

Overview:
Sequencer that owns the inertial sensor's SPI command stream and produces the raw sample pair consumed by the pitch integrator. After reset it waits for the sensor to power up, then writes the sensor configuration registers. After that it waits for the sensor's data-ready interrupt, reads four byte registers, assembles ptch_rt and AZ, and issues a single-cycle vld. It sits between an external 16-bit SPI master (wrt/cmd/done/rd_data handshake) and the integrator.

Parameters:
INIT_WAIT_BITS, 16, width of power-up wait counter; init starts when the counter reaches all ones.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
INT  input  1  sensor data-ready interrupt, asynchronous to clk
done  input  1  SPI master transaction complete, 1-cycle pulse
rd_data  input  16  SPI received word, valid in the cycle done is high
wrt  output  1  SPI transaction request, 1-cycle pulse
cmd  output  16  SPI command word, stable from wrt until done
vld  output  1  new sample pair valid, 1-cycle pulse
ptch_rt  output  16  signed raw pitch rate, {pitchH, pitchL}
AZ  output  16  signed raw Z acceleration, {AZH, AZL}

Behaviour:
- Reset (async, rst_n=0): wrt=0, cmd=16'h0000, vld=0, ptch_rt=0, AZ=0, wait counter=0, state=INIT_WAIT, INT synchronizer flops=0. Reset asserted mid-transaction abandons it immediately. Any later done is ignored until a request is pending.
- INT passes through a 2-flop synchronizer. Only the second flop (INT_s) is used.
- States: INIT_WAIT, INIT_REQ, INIT_ACK, IDLE, RD_REQ, RD_ACK.
- INIT_WAIT:
  - Counter increments every clk.
  - When the counter equals all ones, go to INIT_REQ with init index 0.
- INIT_REQ:
  - wrt=1 for exactly one cycle; cmd = init table entry [index]; go to INIT_ACK.
  - Init table, in order: 16'h0D02 (INT enable), 16'h1053 (accel 208Hz/2g), 16'h1150 (gyro 208Hz/250dps), 16'h1460 (rounding enabled).
- INIT_ACK: wait for done.
  - On done with index<3: index++, go to INIT_REQ.
  - On done with index==3: go to IDLE.
- IDLE: when INT_s=1, read index=0 and go to RD_REQ.
- RD_REQ: wrt=1 for one cycle; cmd = read table entry [index]; go to RD_ACK.
  - Read table, in order: 16'hA200 (pitchL), 16'hA300 (pitchH), 16'hAC00 (AZL), 16'hAD00 (AZH).
- RD_ACK: on done, capture rd_data[7:0] into byte holding register [index].
  - index<3: index++, go to RD_REQ.
  - index==3: go to IDLE.
- Output update on the index==3 done edge, all at the same edge:
  - ptch_rt <= {pitchH, pitchL}
  - AZ <= {rd_data[7:0], AZL}
  - vld <= 1 for exactly one cycle
- ptch_rt and AZ change only on that edge. They hold between samples.
- cmd holds its last value while idle; it is not cleared.
- done is sampled only in INIT_ACK/RD_ACK. It is ignored in every other state, including the cycle wrt is high. rd_data[15:8] is ignored.
- INT high during a read sequence is ignored. It is re-evaluated in IDLE, so INT still high after vld starts a new sequence one cycle later.
- Minimum spacing: wrt at most once every 2 cycles. vld latency from the first done-of-read is at least 3 transactions.
- Counter stops in the all-ones state. It is not reused after init.

Decomposition:
- Package inert_pkg holds:
  - state enum
  - init command table constants (4 x 16-bit)
  - read command table constants (4 x 16-bit)
  - NUM_INIT=4 and NUM_RD=4
- Natural sub-module: inert_int_sync (2-flop synchronizer with async reset). All else is flat in inert_seq_ctrl.
- The SPI master is external and not instantiated here.

Test Plan:
- INIT_WAIT_BITS=4, release reset, SPI model answers done 10 cycles after each wrt → first wrt occurs 16-17 cycles after release with cmd=0D02, followed by 1053, 1150, 1460. No vld and no further wrt until INT.
- After init, raise INT, model returns rd_data 16'hxx34, xx12, xx78, xx56 → cmds A200, A300, AC00, AD00 in order; one vld pulse with ptch_rt=16'h1234, AZ=16'h5678, both stable afterwards.
- Sample with pitch bytes 0xF0/0xFF and AZ bytes 0x00/0x80 → ptch_rt=16'hFFF0 (-16), AZ=16'h8000 (-32768); values pass through unmodified.
- Spurious done pulses in IDLE and coincident with wrt, plus INT toggling during RD_ACK → no extra byte capture, no extra wrt, exactly one vld per sequence.
- Assert rst_n low while in RD_ACK after two bytes are captured → all outputs return to 0 and state returns to INIT_WAIT; the full init sequence repeats before any read.
- Hold INT high continuously → back-to-back read sequences, one vld per 4 dones, no idle gap longer than 2 cycles between sequences.
